// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - forwarding encodings, register width and stage-record layout
package hazard_control_unit_pkg;

  localparam int REG_W = 4;
  localparam int FWD_W = 2;
  localparam int CNT_W = 16;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF = 2'b00,
    FWD_MA = 2'b01,
    FWD_RW = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t dst;
    logic      wb;
    logic      ld;
    logic      st;
    reg_addr_t src2;
  } stage_rec_t;

  localparam stage_rec_t REC_NONE = '0;

  function automatic logic rec_writes(input stage_rec_t rec, input reg_addr_t r);
    return rec.valid && rec.wb && (rec.dst == r);
  endfunction

  // The MA-bound record wins over the RW-bound one because it is younger.
  // A load about to enter MA never supplies EX: load-use stalls prevent
  // that for operands, and store data is patched up in MA instead.
  function automatic fwd_sel_e pick_src(input logic use_it, input reg_addr_t src,
                                        input stage_rec_t ma_bound, input stage_rec_t rw_bound);
    if (!use_it) return FWD_RF;
    if (rec_writes(ma_bound, src)) return ma_bound.ld ? FWD_RF : FWD_MA;
    if (rec_writes(rw_bound, src)) return FWD_RW;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_record.sv
// rtl/hazard_stage_record.sv - one pipeline-stage shadow record with load and bubble control
module hazard_stage_record
  import hazard_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       bubble,
  input  stage_rec_t rec_in,
  output stage_rec_t rec_out
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  always_comb begin
    rec_d = rec_q;
    if (bubble) begin
      rec_d = REC_NONE;
    end else if (load) begin
      rec_d = rec_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_q <= REC_NONE;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_out = rec_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush and operand forwarding control
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter logic [CNT_W-1:0] STALL_CNT_MAX = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             of_valid,
  input  logic [REG_W-1:0] of_src1,
  input  logic [REG_W-1:0] of_src2,
  input  logic             of_use1,
  input  logic             of_use2,
  input  logic             of_is_st,
  input  logic [REG_W-1:0] of_dst,
  input  logic             of_wb,
  input  logic             of_ld,
  input  logic             ex_branch_taken,
  output logic             stall_fetch,
  output logic             bubble_ex,
  output logic             flush_of,
  output logic [FWD_W-1:0] fwd_a_sel,
  output logic [FWD_W-1:0] fwd_b_sel,
  output logic             fwd_st_ma,
  output logic [CNT_W-1:0] stall_count
);

  stage_rec_t of_rec;
  stage_rec_t ex_rec;
  stage_rec_t ma_rec;
  stage_rec_t rw_rec;

  logic load_use;
  logic stall_int;
  logic bubble_int;

  fwd_sel_e         fwd_a_d, fwd_a_q;
  fwd_sel_e         fwd_b_d, fwd_b_q;
  logic             fwd_st_d, fwd_st_q;
  logic [CNT_W-1:0] count_d, count_q;

  assign of_rec = '{valid: of_valid, dst: of_dst, wb: of_wb, ld: of_ld,
                    st: of_is_st, src2: of_src2};

  // Store data alone never stalls on a load: RW->MA forwarding covers it.
  always_comb begin
    load_use = of_valid && ex_rec.valid && ex_rec.ld && ex_rec.wb &&
               ((of_use1 && (of_src1 == ex_rec.dst)) ||
                (of_use2 && !of_is_st && (of_src2 == ex_rec.dst)));
  end

  assign stall_int  = load_use && !ex_branch_taken;
  assign bubble_int = load_use || ex_branch_taken;

  hazard_stage_record u_ex_rec (
    .clk     (clk),
    .reset   (reset),
    .load    (1'b1),
    .bubble  (bubble_int),
    .rec_in  (of_rec),
    .rec_out (ex_rec)
  );

  hazard_stage_record u_ma_rec (
    .clk     (clk),
    .reset   (reset),
    .load    (1'b1),
    .bubble  (1'b0),
    .rec_in  (ex_rec),
    .rec_out (ma_rec)
  );

  hazard_stage_record u_rw_rec (
    .clk     (clk),
    .reset   (reset),
    .load    (1'b1),
    .bubble  (1'b0),
    .rec_in  (ma_rec),
    .rec_out (rw_rec)
  );

  // Selects describe the instruction about to occupy EX after this edge.
  always_comb begin
    fwd_a_d  = FWD_RF;
    fwd_b_d  = FWD_RF;
    fwd_st_d = ex_rec.valid && ex_rec.st && rec_writes(ma_rec, ex_rec.src2);
    count_d  = count_q;
    if (of_valid && !bubble_int) begin
      fwd_a_d = pick_src(of_use1, of_src1, ex_rec, ma_rec);
      fwd_b_d = pick_src(of_use2, of_src2, ex_rec, ma_rec);
    end
    if (stall_int && (count_q != STALL_CNT_MAX)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      fwd_st_q <= 1'b0;
      count_q  <= '0;
    end else begin
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      fwd_st_q <= fwd_st_d;
      count_q  <= count_d;
    end
  end

  // Combinational controls are forced low while reset is held.
  assign stall_fetch = reset && stall_int;
  assign bubble_ex   = reset && bubble_int;
  assign flush_of    = reset && ex_branch_taken;
  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign fwd_st_ma   = fwd_st_q;
  assign stall_count = count_q;

  logic unused_rec;
  assign unused_rec = ^{rw_rec, ma_rec.ld, ma_rec.st, ma_rec.src2};

endmodule
